seq_divider: RTL and testbench

Sequential 8-bit unsigned restoring divider: the inverse of the lab's shift-add multiplier datapath. Divisor and dividend come from the slider switches through two load strobes. A Run press divides the dividend by the divisor, producing one quotient bit per two clocks in a shifting A:Q register pair. Quotient and remainder drive the LED and hex display path; the button synchronizers upstream supply active-high, debounced, clock-aligned strobes.

---
 rtl/seq_divider.sv | 128 ++++++++++++
 tb/tb_seq_divider.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential 8-bit unsigned restoring divider.
// Shifts A:Q left and trial-subtracts M, one quotient bit per two clocks.
module seq_divider (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       LoadM,
   input  logic       LoadQ,
   input  logic       Run,
   input  logic [7:0] S,
   output logic [7:0] Quot,
   output logic [7:0] Rem,
   output logic [7:0] Mval,
   output logic       Busy,
   output logic       Done,
   output logic       DivZero
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      TRIAL,
      HOLD
   } state_t;

   state_t     state, state_nx;
   logic [8:0] a, a_nx;
   logic [7:0] q, q_nx;
   logic [7:0] m, m_nx;
   logic [2:0] cnt, cnt_nx;
   logic       dz, dz_nx;
   logic       run_q;
   logic       start;
   logic [8:0] diff;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         a     <= '0;
         q     <= '0;
         m     <= '0;
         cnt   <= '0;
         dz    <= 1'b0;
         run_q <= 1'b0;
      end else begin
         state <= state_nx;
         a     <= a_nx;
         q     <= q_nx;
         m     <= m_nx;
         cnt   <= cnt_nx;
         dz    <= dz_nx;
         run_q <= Run;
      end
   end

   always_comb begin
      state_nx = state;
      a_nx     = a;
      q_nx     = q;
      m_nx     = m;
      cnt_nx   = cnt;
      dz_nx    = dz;
      start    = Run & ~run_q;
      diff     = a - {1'b0, m};
      unique case (state)
         IDLE: begin
            if (start) begin
               if (m != 8'd0) begin
                  a_nx     = '0;
                  cnt_nx   = '0;
                  dz_nx    = 1'b0;
                  state_nx = SHIFT;
               end else begin
                  // No iteration: quotient saturates, dividend is the remainder
                  a_nx     = {1'b0, q};
                  q_nx     = 8'hFF;
                  dz_nx    = 1'b1;
                  state_nx = HOLD;
               end
            end else begin
               if (LoadM) begin
                  m_nx  = S;
                  dz_nx = 1'b0;
               end
               if (LoadQ) begin
                  q_nx  = S;
                  a_nx  = '0;
                  dz_nx = 1'b0;
               end
            end
         end
         SHIFT: begin
            {a_nx, q_nx} = {a[7:0], q, 1'b0};
            state_nx     = TRIAL;
         end
         TRIAL: begin
            if (!diff[8]) begin
               a_nx = diff;
               q_nx = {q[7:1], 1'b1};
            end else begin
               q_nx = {q[7:1], 1'b0};
            end
            cnt_nx   = cnt + 3'd1;
            state_nx = (cnt == 3'd7) ? HOLD : SHIFT;
         end
         HOLD: begin
            if (LoadM) begin
               m_nx  = S;
               dz_nx = 1'b0;
            end
            if (LoadQ) begin
               q_nx  = S;
               a_nx  = '0;
               dz_nx = 1'b0;
            end
            if (LoadM || LoadQ || !Run) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign Quot    = q;
   assign Rem     = a[7:0];
   assign Mval    = m;
   assign Busy    = (state == SHIFT) || (state == TRIAL);
   assign Done    = (state == HOLD);
   assign DivZero = dz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider.
// Random and directed divisions against an arithmetic reference.
module tb_seq_divider;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       LoadM = 1'b0;
   logic       LoadQ = 1'b0;
   logic       Run = 1'b0;
   logic [7:0] S = 8'd0;
   logic [7:0] Quot, Rem, Mval;
   logic       Busy, Done, DivZero;

   int n_checks = 0;
   int n_fail = 0;

   seq_divider dut (
      .Clk(Clk), .Reset(Reset), .LoadM(LoadM), .LoadQ(LoadQ),
      .Run(Run), .S(S), .Quot(Quot), .Rem(Rem), .Mval(Mval),
      .Busy(Busy), .Done(Done), .DivZero(DivZero)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic load(input logic [7:0] qv, input logic [7:0] mv);
      Run = 1'b0;
      LoadQ = 1'b1; S = qv;
      tick();
      LoadQ = 1'b0; LoadM = 1'b1; S = mv;
      tick();
      LoadM = 1'b0;
   endtask

   // Load, pulse Run, and stop on the first Done cycle.
   task automatic divide(input logic [7:0] qv, input logic [7:0] mv);
      load(qv, mv);
      Run = 1'b1;
      tick();
      Run = 1'b0;
      if (mv != 8'd0) tick(16);
   endtask

   task automatic test_reset;
      Reset = 1'b1;
      tick(2);
      Reset = 1'b0;
      n_checks++;
      if ({Quot, Rem, Mval, Busy, Done, DivZero} !== 27'd0) begin
         n_fail++;
         $display("FAIL reset: got Q=%0d R=%0d M=%0d B%b D%b Z%b want 0",
                  Quot, Rem, Mval, Busy, Done, DivZero);
      end
   endtask

   task automatic test_basic;
      load(8'd100, 8'd7);
      n_checks++;
      if (Mval !== 8'd7 || Quot !== 8'd100) begin
         n_fail++;
         $display("FAIL load: got M=%0d Q=%0d want 7 100", Mval, Quot);
      end
      Run = 1'b1;
      tick();
      Run = 1'b0;
      n_checks++;
      if (Busy !== 1'b1 || Done !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_e1: got B%b D%b want B1 D0", Busy, Done);
      end
      tick(15);
      n_checks++;
      if (Busy !== 1'b1 || Done !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_e16: got B%b D%b want B1 D0", Busy, Done);
      end
      tick();
      n_checks++;
      if ({Quot, Rem, Busy, Done, DivZero} !== {8'd14, 8'd2, 3'b010}) begin
         n_fail++;
         $display("FAIL basic_100_7: got Q=%0d R=%0d B%b D%b Z%b want 14 2 B0 D1 Z0",
                  Quot, Rem, Busy, Done, DivZero);
      end
      tick();
      n_checks++;
      if (Done !== 1'b0 || Quot !== 8'd14 || Rem !== 8'd2) begin
         n_fail++;
         $display("FAIL idle_after: got D%b Q=%0d R=%0d want D0 14 2",
                  Done, Quot, Rem);
      end
   endtask

   task automatic test_corners;
      logic [7:0] qs [3] = '{8'd255, 8'd5, 8'd255};
      logic [7:0] ms [3] = '{8'd1, 8'd9, 8'd255};
      logic [7:0] eq [3] = '{8'd255, 8'd0, 8'd1};
      logic [7:0] er [3] = '{8'd0, 8'd5, 8'd0};
      for (int i = 0; i < 3; i++) begin
         divide(qs[i], ms[i]);
         n_checks++;
         if (Quot !== eq[i] || Rem !== er[i] || Done !== 1'b1) begin
            n_fail++;
            $display("FAIL corner_%0d/%0d: got Q=%0d R=%0d D%b want %0d %0d D1",
                     qs[i], ms[i], Quot, Rem, Done, eq[i], er[i]);
         end
      end
   endtask

   task automatic test_divzero;
      divide(8'd42, 8'd0);
      n_checks++;
      if ({Quot, Rem, Busy, Done, DivZero} !== {8'hFF, 8'd42, 3'b011}) begin
         n_fail++;
         $display("FAIL divzero: got Q=%h R=%0d B%b D%b Z%b want ff 42 B0 D1 Z1",
                  Quot, Rem, Busy, Done, DivZero);
      end
      tick();
      n_checks++;
      if (DivZero !== 1'b1) begin
         n_fail++;
         $display("FAIL divzero_sticky: got Z%b want Z1", DivZero);
      end
      LoadM = 1'b1; S = 8'd5;
      tick();
      LoadM = 1'b0;
      n_checks++;
      if (DivZero !== 1'b0 || Mval !== 8'd5 || Done !== 1'b0) begin
         n_fail++;
         $display("FAIL divzero_clear: got Z%b M=%0d D%b want Z0 5 D0",
                  DivZero, Mval, Done);
      end
   endtask

   task automatic test_hold_run;
      load(8'd200, 8'd3);
      Run = 1'b1;
      tick(40);
      n_checks++;
      if ({Quot, Rem, Busy, Done} !== {8'd66, 8'd2, 2'b01}) begin
         n_fail++;
         $display("FAIL hold_run: got Q=%0d R=%0d B%b D%b want 66 2 B0 D1",
                  Quot, Rem, Busy, Done);
      end
      Run = 1'b0;
      tick();
      n_checks++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_release: got B%b D%b want B0 D0", Busy, Done);
      end
      divide(8'd200, 8'd3);
      n_checks++;
      if (Quot !== 8'd66 || Rem !== 8'd2 || Done !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_rerun: got Q=%0d R=%0d D%b want 66 2 D1",
                  Quot, Rem, Done);
      end
   endtask

   task automatic test_reset_mid;
      load(8'd100, 8'd7);
      Run = 1'b1;
      tick();
      Run = 1'b0;
      tick(4);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      n_checks++;
      if ({Quot, Rem, Mval, Busy, Done, DivZero} !== 27'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got Q=%0d R=%0d M=%0d B%b D%b Z%b want 0",
                  Quot, Rem, Mval, Busy, Done, DivZero);
      end
      tick();
      Run = 1'b1;
      tick();
      Run = 1'b0;
      n_checks++;
      if ({Quot, Rem, Done, DivZero} !== {8'hFF, 8'd0, 2'b11}) begin
         n_fail++;
         $display("FAIL reset_then_run: got Q=%h R=%0d D%b Z%b want ff 0 D1 Z1",
                  Quot, Rem, Done, DivZero);
      end
   endtask

   task automatic test_load_busy;
      load(8'd100, 8'd7);
      Run = 1'b1;
      tick();
      Run = 1'b0;
      tick(2);
      LoadM = 1'b1; S = 8'd3;
      tick();
      LoadM = 1'b0;
      n_checks++;
      if (Mval !== 8'd7 || Busy !== 1'b1) begin
         n_fail++;
         $display("FAIL load_busy_m: got M=%0d B%b want 7 B1", Mval, Busy);
      end
      tick(13);
      n_checks++;
      if (Quot !== 8'd14 || Rem !== 8'd2 || Done !== 1'b1) begin
         n_fail++;
         $display("FAIL load_busy_res: got Q=%0d R=%0d D%b want 14 2 D1",
                  Quot, Rem, Done);
      end
   endtask

   task automatic test_random;
      logic [7:0] qv, mv, eq, er;
      logic       ez;
      for (int i = 0; i < 40; i++) begin
         qv = 8'($urandom);
         mv = (i % 8 == 7) ? 8'd0 : 8'($urandom);
         if (mv == 8'd0) begin
            eq = 8'hFF; er = qv; ez = 1'b1;
         end else begin
            eq = qv / mv; er = qv % mv; ez = 1'b0;
         end
         divide(qv, mv);
         n_checks++;
         if (Quot !== eq || Rem !== er || DivZero !== ez || Done !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_%0d/%0d: got Q=%0d R=%0d Z%b D%b want %0d %0d Z%b D1",
                     qv, mv, Quot, Rem, DivZero, Done, eq, er, ez);
         end
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_basic();
      test_corners();
      test_divzero();
      test_hold_run();
      test_reset_mid();
      test_load_busy();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
